// File: rtl/vpu_pkg.sv
// Shared widths, opcode and state encodings, and the command record for the
// VPU source-side issuer.
package vpu_pkg;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;
  localparam int OP_W   = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_MUL = 5'd2,
    OP_MAC = 5'd3,
    OP_MAX = 5'd4,
    OP_MIN = 5'd5
  } vpu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } issuer_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [1:0]        num_src;
    logic [ADDR_W-1:0] src0_addr;
    logic [ADDR_W-1:0] src1_addr;
    logic [ADDR_W-1:0] src2_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  // An operand count of zero is treated as a single operand.
  function automatic logic [1:0] eff_num_src(input logic [1:0] n);
    return (n == 2'd0) ? 2'd1 : n;
  endfunction

endpackage

// File: rtl/vpu_src_addr_gen.sv
// Row / operand-index counters and the derived SRAM read and destination
// addresses. Address sums wrap silently at the address width.
module vpu_src_addr_gen
  import vpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              k_inc_i,
  input  logic              row_inc_i,
  input  logic [ADDR_W-1:0] src0_base_i,
  input  logic [ADDR_W-1:0] src1_base_i,
  input  logic [ADDR_W-1:0] src2_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  output logic [1:0]        k_o,
  output logic [LEN_W-1:0]  row_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o
);

  logic [1:0]        k_q, k_d;
  logic [LEN_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base;

  // Next counter values: a new command clears both, a new row restarts k.
  always_comb begin
    k_d   = k_q;
    row_d = row_q;
    if (clear_i) begin
      k_d   = 2'd0;
      row_d = '0;
    end else if (row_inc_i) begin
      k_d   = 2'd0;
      row_d = row_q + LEN_W'(1);
    end else if (k_inc_i) begin
      k_d   = k_q + 2'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= 2'd0;
      row_q <= '0;
    end else begin
      k_q   <= k_d;
      row_q <= row_d;
    end
  end

  // Select the operand base for the read currently being issued.
  always_comb begin
    case (k_q)
      2'd1:    base = src1_base_i;
      2'd2:    base = src2_base_i;
      default: base = src0_base_i;
    endcase
  end

  assign k_o        = k_q;
  assign row_o      = row_q;
  assign rd_addr_o  = base + ADDR_W'(row_q);
  assign dst_addr_o = dst_base_i + ADDR_W'(row_q);

endmodule

// File: rtl/vpu_src_issuer.sv
// VPU source-port issuer: latches a command, reads up to three operand rows
// per element-row from the operand SRAM, and presents each row as one
// valid/ready beat. A single-cycle done pulse follows the last accepted row.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a command
// ST_FETCH | one SRAM read per cycle, operand k of the current row
// ST_WAIT  | last read data returning, captured at the end of this cycle
// ST_SEND  | beat presented, held until src_ready
// ST_DONE  | done pulse, then back to idle
module vpu_src_issuer
  import vpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OP_W-1:0]   cmd_opcode_i,
  input  logic [1:0]        cmd_num_src_i,
  input  logic [ADDR_W-1:0] cmd_src0_addr_i,
  input  logic [ADDR_W-1:0] cmd_src1_addr_i,
  input  logic [ADDR_W-1:0] cmd_src2_addr_i,
  input  logic [ADDR_W-1:0] cmd_dst_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              sram_rd_en_o,
  output logic [ADDR_W-1:0] sram_rd_addr_o,
  input  logic [DATA_W-1:0] sram_rd_data_i,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic [OP_W-1:0]   src_opcode_o,
  output logic [DATA_W-1:0] src_data0_o,
  output logic [DATA_W-1:0] src_data1_o,
  output logic [DATA_W-1:0] src_data2_o,
  output logic [ADDR_W-1:0] src_dst_addr_o,
  output logic              src_last_o,
  output logic              busy_o,
  output logic              done_o
);

  issuer_state_e     state_q, state_d;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] opnd0_q, opnd1_q, opnd2_q;
  logic              cap_en_q;
  logic [1:0]        cap_idx_q;
  logic [1:0]        k;
  logic [LEN_W-1:0]  row;
  logic              accept, handshake, last_row, fetch_last;

  assign accept     = cmd_valid_i & cmd_ready_o;
  assign handshake  = src_valid_o & src_ready_i;
  assign last_row   = (row == cmd_q.len - LEN_W'(1));
  assign fetch_last = (k == cmd_q.num_src - 2'd1);

  vpu_src_addr_gen u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (accept),
    .k_inc_i     (state_q == ST_FETCH),
    .row_inc_i   (handshake & ~last_row),
    .src0_base_i (cmd_q.src0_addr),
    .src1_base_i (cmd_q.src1_addr),
    .src2_base_i (cmd_q.src2_addr),
    .dst_base_i  (cmd_q.dst_addr),
    .k_o         (k),
    .row_o       (row),
    .rd_addr_o   (sram_rd_addr_o),
    .dst_addr_o  (src_dst_addr_o)
  );

  // Latch the command on accept; the operand count is normalised here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
    end else if (accept) begin
      cmd_q <= '{opcode:    cmd_opcode_i,
                 num_src:   eff_num_src(cmd_num_src_i),
                 src0_addr: cmd_src0_addr_i,
                 src1_addr: cmd_src1_addr_i,
                 src2_addr: cmd_src2_addr_i,
                 dst_addr:  cmd_dst_addr_i,
                 len:       cmd_len_i};
    end
  end

  // SRAM data arrives one cycle after the strobe; remember which operand
  // it belongs to and store it on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en_q  <= 1'b0;
      cap_idx_q <= 2'd0;
      opnd0_q   <= '0;
      opnd1_q   <= '0;
      opnd2_q   <= '0;
    end else begin
      cap_en_q  <= sram_rd_en_o;
      cap_idx_q <= k;
      if (cap_en_q) begin
        case (cap_idx_q)
          2'd0:    opnd0_q <= sram_rd_data_i;
          2'd1:    opnd1_q <= sram_rd_data_i;
          default: opnd2_q <= sram_rd_data_i;
        endcase
      end
    end
  end

  // Sequencing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (cmd_len_i == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (fetch_last) state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_SEND;
      ST_SEND:  if (handshake) state_d = last_row ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign sram_rd_en_o = (state_q == ST_FETCH);
  assign src_valid_o  = (state_q == ST_SEND);
  assign done_o       = (state_q == ST_DONE);
  assign src_last_o   = (state_q == ST_SEND) & last_row;
  assign src_opcode_o = cmd_q.opcode;
  assign src_data0_o  = opnd0_q;
  assign src_data1_o  = (cmd_q.num_src >= 2'd2) ? opnd1_q : '0;
  assign src_data2_o  = (cmd_q.num_src == 2'd3) ? opnd2_q : '0;

endmodule

// File: tb/tb_vpu_src_issuer.sv
// Bench for vpu_src_issuer: SRAM model with random contents, negedge monitor,
// and a row-level reference model of expected reads and beats.
module tb_vpu_src_issuer;
  import vpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_opcode = '0;
  logic [1:0]        cmd_num_src = '0;
  logic [ADDR_W-1:0] cmd_src0_addr = '0, cmd_src1_addr = '0, cmd_src2_addr = '0;
  logic [ADDR_W-1:0] cmd_dst_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic [DATA_W-1:0] sram_rd_data;
  logic              src_valid;
  logic              src_ready = 1'b0;
  logic [OP_W-1:0]   src_opcode;
  logic [DATA_W-1:0] src_data0, src_data1, src_data2;
  logic [ADDR_W-1:0] src_dst_addr;
  logic              src_last, busy, done;

  vpu_src_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_opcode_i(cmd_opcode),
    .cmd_num_src_i(cmd_num_src), .cmd_src0_addr_i(cmd_src0_addr),
    .cmd_src1_addr_i(cmd_src1_addr), .cmd_src2_addr_i(cmd_src2_addr),
    .cmd_dst_addr_i(cmd_dst_addr), .cmd_len_i(cmd_len),
    .sram_rd_en_o(sram_rd_en), .sram_rd_addr_o(sram_rd_addr), .sram_rd_data_i(sram_rd_data),
    .src_valid_o(src_valid), .src_ready_i(src_ready), .src_opcode_o(src_opcode),
    .src_data0_o(src_data0), .src_data1_o(src_data1), .src_data2_o(src_data2),
    .src_dst_addr_o(src_dst_addr), .src_last_o(src_last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d0, d1, d2;
    logic [ADDR_W-1:0] dst;
    logic              last;
    logic [OP_W-1:0]   op;
    int                cyc;
  } beat_t;

  logic [DATA_W-1:0] mem [1024];
  int                cyc = 0;
  int                chk_cnt = 0;
  int                pass_cnt = 0;
  logic [ADDR_W-1:0] rd_q[$], exp_rd[$];
  beat_t             beat_q[$], exp_beat[$];
  int                done_q[$], vstart_q[$];
  logic              valid_prev = 1'b0;
  beat_t             mon_b;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];

  always @(negedge clk) begin
    if (sram_rd_en) rd_q.push_back(sram_rd_addr);
    if (src_valid && src_ready) begin
      mon_b.d0 = src_data0; mon_b.d1 = src_data1; mon_b.d2 = src_data2;
      mon_b.dst = src_dst_addr; mon_b.last = src_last; mon_b.op = src_opcode;
      mon_b.cyc = cyc;
      beat_q.push_back(mon_b);
    end
    if (done) done_q.push_back(cyc);
    if (src_valid && !valid_prev) vstart_q.push_back(cyc);
    valid_prev = src_valid;
  end

  function automatic cmd_t mk(input int op, input int num, input int s0, input int s1,
                              input int s2, input int dst, input int len);
    cmd_t c;
    c.opcode = OP_W'(op); c.num_src = 2'(num);
    c.src0_addr = ADDR_W'(s0); c.src1_addr = ADDR_W'(s1); c.src2_addr = ADDR_W'(s2);
    c.dst_addr = ADDR_W'(dst); c.len = LEN_W'(len);
    return c;
  endfunction

  function automatic int eff_n(input cmd_t c);
    return (c.num_src == 2'd0) ? 1 : int'(c.num_src);
  endfunction

  // Reference model: every row reads operand k at base_k+row, then emits one beat.
  task automatic build_exp(input cmd_t c);
    int n;
    int a [3];
    beat_t b;
    n = eff_n(c);
    exp_rd.delete(); exp_beat.delete();
    for (int r = 0; r < int'(c.len); r++) begin
      a[0] = (int'(c.src0_addr) + r) % 1024;
      a[1] = (int'(c.src1_addr) + r) % 1024;
      a[2] = (int'(c.src2_addr) + r) % 1024;
      for (int k = 0; k < n; k++) exp_rd.push_back(ADDR_W'(a[k]));
      b.d0 = mem[a[0]];
      b.d1 = (n >= 2) ? mem[a[1]] : '0;
      b.d2 = (n >= 3) ? mem[a[2]] : '0;
      b.dst = ADDR_W'((int'(c.dst_addr) + r) % 1024);
      b.last = (r == int'(c.len) - 1);
      b.op = c.opcode;
      b.cyc = 0;
      exp_beat.push_back(b);
    end
  endtask

  function automatic int rd_errs();
    int e = 0;
    if (rd_q.size() != exp_rd.size()) return 1000;
    foreach (exp_rd[i]) if (rd_q[i] !== exp_rd[i]) e++;
    return e;
  endfunction

  function automatic int beat_errs();
    int e = 0;
    if (beat_q.size() != exp_beat.size()) return 1000;
    foreach (exp_beat[i])
      if (beat_q[i].d0 !== exp_beat[i].d0 || beat_q[i].d1 !== exp_beat[i].d1 ||
          beat_q[i].d2 !== exp_beat[i].d2 || beat_q[i].dst !== exp_beat[i].dst ||
          beat_q[i].last !== exp_beat[i].last || beat_q[i].op !== exp_beat[i].op) e++;
    return e;
  endfunction

  task automatic clear_mon();
    rd_q.delete(); beat_q.delete(); done_q.delete(); vstart_q.delete();
  endtask

  task automatic issue(input cmd_t c, output int t_acc, output bit ok);
    @(posedge clk); #1;
    cmd_opcode = c.opcode; cmd_num_src = c.num_src;
    cmd_src0_addr = c.src0_addr; cmd_src1_addr = c.src1_addr; cmd_src2_addr = c.src2_addr;
    cmd_dst_addr = c.dst_addr; cmd_len = c.len;
    cmd_valid = 1'b1;
    ok = 1'b0; t_acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin t_acc = cyc; ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_q.size() > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_ready = 1'b0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); else pass_cnt++;
    chk_cnt++; if (src_valid !== 1'b0) $display("FAIL rst_src_valid got %b want 0", src_valid); else pass_cnt++;
    chk_cnt++; if (sram_rd_en !== 1'b0) $display("FAIL rst_rd_en got %b want 0", sram_rd_en); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_done_busy got %b%b want 00", done, busy); else pass_cnt++;
    chk_cnt++; if (src_last !== 1'b0 || src_data0 !== '0) $display("FAIL rst_src_out got last=%b d0=%h want 0", src_last, src_data0); else pass_cnt++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL post_rst_idle got ready=%b busy=%b want 1/0", cmd_ready, busy); else pass_cnt++;
  endtask

  task automatic test_single_row();
    cmd_t c; int t; bit ok, okd;
    c = mk(3, 2, 'h010, 'h020, 'h000, 'h100, 1);
    clear_mon(); src_ready = 1'b1;
    issue(c, t, ok); wait_done(100, okd);
    chk_cnt++; if (!ok || !okd) $display("FAIL single_complete got acc=%b done=%b want 1/1", ok, okd); else pass_cnt++;
    chk_cnt++; if (rd_q.size() != 2 || rd_q[0] !== 10'h010 || rd_q[1] !== 10'h020)
      $display("FAIL single_reads got n=%0d a0=%h a1=%h want 2 010 020", rd_q.size(), rd_q[0], rd_q[1]); else pass_cnt++;
    chk_cnt++; if (beat_q.size() != 1 || beat_q[0].cyc != t + 4)
      $display("FAIL single_latency got n=%0d cyc=%0d want 1 %0d", beat_q.size(), beat_q[0].cyc, t + 4); else pass_cnt++;
    chk_cnt++; if (beat_q[0].d0 !== mem['h010] || beat_q[0].d1 !== mem['h020] || beat_q[0].d2 !== '0)
      $display("FAIL single_data got d0=%h d1=%h d2=%h", beat_q[0].d0, beat_q[0].d1, beat_q[0].d2); else pass_cnt++;
    chk_cnt++; if (beat_q[0].last !== 1'b1 || beat_q[0].dst !== 10'h100 || beat_q[0].op !== 5'd3)
      $display("FAIL single_ctl got last=%b dst=%h op=%h want 1 100 03", beat_q[0].last, beat_q[0].dst, beat_q[0].op); else pass_cnt++;
    chk_cnt++; if (done_q.size() != 1 || done_q[0] != t + 5)
      $display("FAIL single_done got n=%0d cyc=%0d want 1 %0d", done_q.size(), done_q[0], t + 5); else pass_cnt++;
  endtask

  task automatic test_stall();
    cmd_t c; int t, s_cyc; bit ok, okd, seen, stable;
    logic [DATA_W-1:0] s0, s1, s2; logic [ADDR_W-1:0] sd; logic sl;
    c = mk(7, 3, 'h040, 'h080, 'h0C0, 'h100, 4);
    build_exp(c); clear_mon(); src_ready = 1'b1;
    issue(c, t, ok);
    for (int i = 0; i < 50 && beat_q.size() < 1; i++) @(negedge clk);
    @(posedge clk); #1; src_ready = 1'b0;
    seen = 1'b0; s_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_valid) begin seen = 1'b1; s_cyc = cyc; break; end
    end
    s0 = src_data0; s1 = src_data1; s2 = src_data2; sd = src_dst_addr; sl = src_last;
    stable = seen;
    repeat (4) begin
      @(negedge clk);
      if (!src_valid || src_data0 !== s0 || src_data1 !== s1 || src_data2 !== s2 ||
          src_dst_addr !== sd || src_last !== sl) stable = 1'b0;
    end
    @(posedge clk); #1; src_ready = 1'b1;
    wait_done(200, okd);
    chk_cnt++; if (!stable) $display("FAIL stall_stable got %b want 1", stable); else pass_cnt++;
    chk_cnt++; if (beat_errs() != 0) $display("FAIL stall_beats got %0d bad (n=%0d) want 0", beat_errs(), beat_q.size()); else pass_cnt++;
    chk_cnt++; if (beat_q[1].cyc != s_cyc + 5) $display("FAIL stall_release got %0d want %0d", beat_q[1].cyc, s_cyc + 5); else pass_cnt++;
    chk_cnt++; if (!okd || done_q.size() != 1) $display("FAIL stall_done got n=%0d want 1", done_q.size()); else pass_cnt++;
    chk_cnt++; if (rd_errs() != 0) $display("FAIL stall_reads got %0d bad want 0", rd_errs()); else pass_cnt++;
  endtask

  task automatic test_wrap();
    cmd_t c; int t; bit ok, okd;
    c = mk(1, 1, 'h3FE, 'h000, 'h000, 'h3FF, 3);
    build_exp(c); clear_mon(); src_ready = 1'b1;
    issue(c, t, ok); wait_done(100, okd);
    chk_cnt++; if (rd_q.size() != 3 || rd_q[0] !== 10'h3FE || rd_q[1] !== 10'h3FF || rd_q[2] !== 10'h000)
      $display("FAIL wrap_reads got n=%0d %h %h %h want 3FE 3FF 000", rd_q.size(), rd_q[0], rd_q[1], rd_q[2]); else pass_cnt++;
    chk_cnt++; if (beat_q[1].dst !== 10'h000) $display("FAIL wrap_dst got %h want 000", beat_q[1].dst); else pass_cnt++;
    chk_cnt++; if (beat_errs() != 0) $display("FAIL wrap_beats got %0d bad want 0", beat_errs()); else pass_cnt++;
  endtask

  task automatic test_len_zero();
    cmd_t c; int t; bit ok;
    c = mk(2, 2, 'h011, 'h022, 'h033, 'h044, 0);
    clear_mon(); src_ready = 1'b1;
    issue(c, t, ok);
    @(negedge clk);
    chk_cnt++; if (done !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL len0_pulse got done=%b ready=%b want 1/0", done, cmd_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL len0_back got done=%b ready=%b want 0/1", done, cmd_ready); else pass_cnt++;
    chk_cnt++; if (done_q.size() != 1 || done_q[0] != t + 1) $display("FAIL len0_done_cyc got %0d want %0d", done_q[0], t + 1); else pass_cnt++;
    chk_cnt++; if (rd_q.size() != 0 || vstart_q.size() != 0)
      $display("FAIL len0_quiet got reads=%0d valids=%0d want 0 0", rd_q.size(), vstart_q.size()); else pass_cnt++;
  endtask

  task automatic test_num_src_zero();
    cmd_t c; int t; bit ok, okd;
    c = mk(4, 0, 'h050, 'h060, 'h070, 'h200, 2);
    build_exp(c); clear_mon(); src_ready = 1'b1;
    issue(c, t, ok); wait_done(100, okd);
    chk_cnt++; if (rd_q.size() != 2 || rd_q[0] !== 10'h050 || rd_q[1] !== 10'h051)
      $display("FAIL num0_reads got n=%0d %h %h want 2 050 051", rd_q.size(), rd_q[0], rd_q[1]); else pass_cnt++;
    chk_cnt++; if (beat_q[0].d1 !== '0 || beat_q[0].d2 !== '0 || beat_q[1].d1 !== '0)
      $display("FAIL num0_zero got d1=%h d2=%h", beat_q[0].d1, beat_q[0].d2); else pass_cnt++;
    chk_cnt++; if (beat_errs() != 0) $display("FAIL num0_beats got %0d bad want 0", beat_errs()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    cmd_t c; int t; bit ok, okd, seen;
    c = mk(5, 2, 'h200, 'h300, 'h000, 'h010, 4);
    clear_mon(); src_ready = 1'b1;
    issue(c, t, ok);
    for (int i = 0; i < 100 && beat_q.size() < 2; i++) @(negedge clk);
    @(posedge clk); #1; src_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_valid) begin seen = 1'b1; break; end
    end
    #2; rst_n = 1'b0; #1;
    chk_cnt++; if (!seen || src_valid !== 1'b0 || sram_rd_en !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst_drop got seen=%b valid=%b rd=%b done=%b", seen, src_valid, sram_rd_en, done); else pass_cnt++;
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midrst_idle got ready=%b busy=%b", cmd_ready, busy); else pass_cnt++;
    chk_cnt++; if (done_q.size() != 0) $display("FAIL midrst_nodone got %0d pulses want 0", done_q.size()); else pass_cnt++;
    c = mk(6, 3, 'h123, 'h234, 'h345, 'h0F0, 2);
    build_exp(c); clear_mon(); src_ready = 1'b1;
    issue(c, t, ok); wait_done(100, okd);
    chk_cnt++; if (!okd || beat_errs() != 0 || rd_errs() != 0 || done_q.size() != 1)
      $display("FAIL midrst_next got done=%b beat_bad=%0d rd_bad=%0d", okd, beat_errs(), rd_errs()); else pass_cnt++;
  endtask

  task automatic test_random();
    cmd_t c; int t, n; bit ok;
    for (int it = 0; it < 25; it++) begin
      c.opcode = OP_W'($urandom); c.num_src = 2'($urandom_range(0, 3));
      c.src0_addr = ADDR_W'($urandom); c.src1_addr = ADDR_W'($urandom);
      c.src2_addr = ADDR_W'($urandom); c.dst_addr = ADDR_W'($urandom);
      c.len = ($urandom_range(0, 9) == 0) ? '0 : LEN_W'($urandom_range(1, 5));
      n = eff_n(c);
      build_exp(c); clear_mon();
      src_ready = 1'($urandom_range(0, 1));
      issue(c, t, ok);
      for (int i = 0; i < 400; i++) begin
        if (done_q.size() > 0) break;
        @(posedge clk); #1; src_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk_cnt++; if (!ok || done_q.size() != 1) $display("FAIL rnd%0d_done got acc=%b n=%0d want 1", it, ok, done_q.size()); else pass_cnt++;
      chk_cnt++; if (rd_errs() != 0) $display("FAIL rnd%0d_reads got %0d bad want 0", it, rd_errs()); else pass_cnt++;
      chk_cnt++; if (beat_errs() != 0) $display("FAIL rnd%0d_beats got %0d bad want 0", it, beat_errs()); else pass_cnt++;
      chk_cnt++; if (vstart_q.size() != int'(c.len))
        $display("FAIL rnd%0d_valid_runs got %0d want %0d", it, vstart_q.size(), c.len); else pass_cnt++;
      chk_cnt++;
      if (c.len == 0) begin
        if (done_q[0] != t + 1) $display("FAIL rnd%0d_lat got %0d want %0d", it, done_q[0], t + 1); else pass_cnt++;
      end else begin
        if (vstart_q[0] != t + n + 2) $display("FAIL rnd%0d_lat got %0d want %0d", it, vstart_q[0], t + n + 2); else pass_cnt++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int j = 0; j < DATA_W / 32; j++) mem[i][j*32 +: 32] = $urandom;
    test_reset();
    test_single_row();
    test_stall();
    test_wrap();
    test_len_zero();
    test_num_src_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion (%0d/%0d passed)", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
